// File: rtl/instruction_fetch.sv
// Fetch front end: keeps the fetch PC, issues word reads, buffers returned words in an
// in-order FIFO and presents the head instruction (or NOP) to decode.

module instruction_fetch_chk (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  logic full
);
    push_to_full_a: assert property (@(posedge clk) disable iff (!rst) !(push && full && !pop));
endmodule

module instruction_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        stall_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_valid_o
);
    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam int          CW      = AW + 1;
    localparam logic [31:0] NOP     = 32'hE320_F000;
    localparam logic [CW:0] DEPTH_L = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic [0:0] {RUN = 1'b0, DRAIN = 1'b1} state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [31:0]   fetch_pc_r;
    logic [31:0]   resp_pc_r;
    logic [CW-1:0] outstanding_r;
    logic [CW-1:0] drop_cnt_r;
    logic [CW-1:0] fifo_count_r;
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [31:0]   data_mem_r [FIFO_DEPTH];
    logic [31:0]   pc_mem_r   [FIFO_DEPTH];
    logic [CW:0]   credit_use_s;
    logic [CW-1:0] remain_s;
    logic          req_s;
    logic          xfer_s;
    logic          push_s;
    logic          pop_s;
    logic          full_s;

    // Credits count both in-flight reads and buffered words, so a response always has a slot.
    assign credit_use_s  = {1'b0, outstanding_r} + {1'b0, fifo_count_r};
    assign remain_s      = outstanding_r - CW'(mem_rvalid_i);
    assign req_s         = rst && (state_r == RUN) && !redirect_i && (credit_use_s < DEPTH_L);
    assign xfer_s        = req_s && mem_gnt_i;
    assign push_s        = mem_rvalid_i && (state_r == RUN) && !redirect_i;
    assign instr_valid_o = (fifo_count_r != {CW{1'b0}});
    assign pop_s         = instr_valid_o && !stall_i && !redirect_i;
    assign full_s        = (fifo_count_r == CW'(FIFO_DEPTH));

    assign mem_req_o  = req_s;
    assign mem_addr_o = fetch_pc_r;
    assign instr_o    = instr_valid_o ? data_mem_r[rd_ptr_r] : NOP;
    assign instr_pc_o = instr_valid_o ? pc_mem_r[rd_ptr_r] : 32'h0000_0000;

    // Next-state selection for the RUN/DRAIN sequencer
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            RUN: begin
                if (redirect_i && (remain_s != {CW{1'b0}})) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DRAIN: begin
                if (mem_rvalid_i && (drop_cnt_r == CW'(1))) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            default: state_nxt_s = RUN;
        endcase
    end

    // Fetch PC, response PC, in-flight and drop counters, sequencer state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= RUN;
            fetch_pc_r    <= RESET_PC;
            resp_pc_r     <= RESET_PC;
            outstanding_r <= {CW{1'b0}};
            drop_cnt_r    <= {CW{1'b0}};
        end else begin
            state_r       <= state_nxt_s;
            outstanding_r <= outstanding_r + CW'(xfer_s) - CW'(mem_rvalid_i);
            if (redirect_i) begin
                fetch_pc_r <= {redirect_pc_i[31:2], 2'b00};
                resp_pc_r  <= {redirect_pc_i[31:2], 2'b00};
            end else begin
                if (xfer_s) begin
                    fetch_pc_r <= fetch_pc_r + 32'd4;
                end
                if (push_s) begin
                    resp_pc_r <= resp_pc_r + 32'd4;
                end
            end
            if ((state_r == RUN) && redirect_i) begin
                drop_cnt_r <= remain_s;
            end else if ((state_r == DRAIN) && mem_rvalid_i) begin
                drop_cnt_r <= drop_cnt_r - CW'(1);
            end
        end
    end

    // Instruction buffer; a redirect empties it ahead of any push or pop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r     <= {AW{1'b0}};
            rd_ptr_r     <= {AW{1'b0}};
            fifo_count_r <= {CW{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_mem_r[i] <= 32'h0000_0000;
                pc_mem_r[i]   <= 32'h0000_0000;
            end
        end else if (redirect_i) begin
            wr_ptr_r     <= {AW{1'b0}};
            rd_ptr_r     <= {AW{1'b0}};
            fifo_count_r <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                data_mem_r[wr_ptr_r] <= mem_rdata_i;
                pc_mem_r[wr_ptr_r]   <= resp_pc_r;
                wr_ptr_r             <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            fifo_count_r <= fifo_count_r + CW'(push_s) - CW'(pop_s);
        end
    end

    instruction_fetch_chk u_chk (
        .clk  (clk),
        .rst  (rst),
        .push (push_s),
        .pop  (pop_s),
        .full (full_s)
    );
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a zero-wait memory model answers grants one cycle
// later, with an enable to hold responses back while a redirect is exercised.

module tb_instruction_fetch;
    logic        clk;
    logic        rst;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        stall_i;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_valid_o;

    logic        hi_req;
    logic [31:0] hi_addr;
    logic [31:0] hi_instr;
    logic [31:0] hi_instr_pc;
    logic        hi_valid;

    int          n_checks;
    int          n_errors;
    int          n_grants;
    logic        resp_en;
    logic [31:0] pend_q [$];

    localparam logic [31:0] NOP = 32'hE320_F000;
    logic [31:0] exp_w  [4] = '{32'hC0DE_0000, 32'hC0DE_0004, 32'hC0DE_0008, 32'hC0DE_000C};
    logic [31:0] exp_pc [4] = '{32'h0000_0000, 32'h0000_0004, 32'h0000_0008, 32'h0000_000C};

    instruction_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .stall_i       (stall_i),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_valid_o (instr_valid_o)
    );

    instruction_fetch #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(4)) u_dut_hi (
        .clk           (clk),
        .rst           (rst),
        .mem_req_o     (hi_req),
        .mem_addr_o    (hi_addr),
        .mem_gnt_i     (1'b1),
        .mem_rvalid_i  (1'b0),
        .mem_rdata_i   (32'h0000_0000),
        .redirect_i    (1'b0),
        .redirect_pc_i (32'h0000_0000),
        .stall_i       (1'b1),
        .instr_o       (hi_instr),
        .instr_pc_o    (hi_instr_pc),
        .instr_valid_o (hi_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Runs to the next cycle: records a grant at the edge, then drives that cycle's response.
    task automatic next_cycle();
        logic        xfer;
        logic [31:0] addr;
        #1;
        xfer = mem_req_o && mem_gnt_i;
        addr = mem_addr_o;
        @(posedge clk);
        if (xfer) begin
            pend_q.push_back(addr);
            n_grants++;
        end
        @(negedge clk);
        if (resp_en && (pend_q.size() > 0)) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = mem_word(pend_q.pop_front());
        end else begin
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = 32'h0000_0000;
        end
        #1;
    endtask

    task automatic apply_reset();
        rst           = 1'b0;
        mem_gnt_i     = 1'b1;
        mem_rvalid_i  = 1'b0;
        mem_rdata_i   = 32'h0000_0000;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0000_0000;
        stall_i       = 1'b0;
        resp_en       = 1'b1;
        n_grants      = 0;
        pend_q.delete();
        #1;
    endtask

    task automatic release_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        resp_en  = 1'b1;
        mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i = 32'h0000_0000;
        redirect_i = 1'b0;
        redirect_pc_i = 32'h0000_0000;
        stall_i = 1'b0;
        @(negedge clk);

        // Reset state
        apply_reset();
        check32("rst_req", mem_req_o, 32'd0);
        check32("rst_addr", mem_addr_o, 32'h0000_0000);
        check32("rst_valid", instr_valid_o, 32'd0);
        check32("rst_instr", instr_o, NOP);
        check32("rst_pc", instr_pc_o, 32'h0000_0000);
        check32("rst_hi_addr", hi_addr, 32'hFFFF_FFF8);

        // Streaming fetch with zero-wait memory; high-address instance wraps alongside
        release_reset();
        check32("t1_req_c1", mem_req_o, 32'd1);
        check32("t1_addr_c1", mem_addr_o, 32'h0000_0000);
        check32("t1_valid_c1", instr_valid_o, 32'd0);
        check32("t5_addr_c1", hi_addr, 32'hFFFF_FFF8);
        check32("t5_req_c1", hi_req, 32'd1);
        next_cycle();
        check32("t1_addr_c2", mem_addr_o, 32'h0000_0004);
        check32("t1_valid_c2", instr_valid_o, 32'd0);
        check32("t5_addr_c2", hi_addr, 32'hFFFF_FFFC);
        next_cycle();
        check32("t5_addr_c3", hi_addr, 32'h0000_0000);
        check32("t5_valid", hi_valid, 32'd0);
        for (int i = 0; i < 4; i++) begin
            check32("t1_valid", instr_valid_o, 32'd1);
            check32("t1_instr", instr_o, exp_w[i]);
            check32("t1_pc", instr_pc_o, exp_pc[i]);
            next_cycle();
        end

        // Stall from cycle 3: credits allow exactly four grants, then drain in order
        apply_reset();
        release_reset();
        next_cycle();
        next_cycle();
        stall_i = 1'b1;
        repeat (8) next_cycle();
        check32("t2_grants", n_grants, 32'd4);
        check32("t2_req_off", mem_req_o, 32'd0);
        check32("t2_hold", instr_o, exp_w[0]);
        stall_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check32("t2_instr", instr_o, exp_w[i]);
            check32("t2_pc", instr_pc_o, exp_pc[i]);
            next_cycle();
        end

        // Redirect to 0x103 with two reads in flight: both responses dropped
        apply_reset();
        resp_en = 1'b0;
        release_reset();
        next_cycle();
        next_cycle();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0103;
        resp_en       = 1'b1;
        #1;
        check32("t3_req_redir", mem_req_o, 32'd0);
        next_cycle();
        redirect_i = 1'b0;
        #1;
        check32("t3_grants", n_grants, 32'd2);
        check32("t3_req_drain1", mem_req_o, 32'd0);
        next_cycle();
        check32("t3_req_drain2", mem_req_o, 32'd0);
        check32("t3_valid_drain", instr_valid_o, 32'd0);
        next_cycle();
        check32("t3_req_new", mem_req_o, 32'd1);
        check32("t3_addr_new", mem_addr_o, 32'h0000_0100);
        check32("t3_valid_new", instr_valid_o, 32'd0);
        next_cycle();
        check32("t3_valid_resp", instr_valid_o, 32'd0);
        next_cycle();
        check32("t3_valid", instr_valid_o, 32'd1);
        check32("t3_pc", instr_pc_o, 32'h0000_0100);
        check32("t3_instr", instr_o, 32'hC0DE_0100);

        // Redirect in the same cycle as the only outstanding response: no drain
        apply_reset();
        release_reset();
        next_cycle();
        check32("t4_rvalid_here", mem_rvalid_i, 32'd1);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0200;
        #1;
        check32("t4_req_redir", mem_req_o, 32'd0);
        next_cycle();
        redirect_i = 1'b0;
        #1;
        check32("t4_req_new", mem_req_o, 32'd1);
        check32("t4_addr_new", mem_addr_o, 32'h0000_0200);
        check32("t4_no_stale", instr_valid_o, 32'd0);
        next_cycle();
        check32("t4_no_stale2", instr_valid_o, 32'd0);
        next_cycle();
        check32("t4_valid", instr_valid_o, 32'd1);
        check32("t4_instr", instr_o, 32'hC0DE_0200);
        check32("t4_pc", instr_pc_o, 32'h0000_0200);

        // Reset asserted mid-stream with a full buffer clears outputs immediately
        apply_reset();
        release_reset();
        stall_i = 1'b1;
        repeat (8) next_cycle();
        check32("t6_pre_valid", instr_valid_o, 32'd1);
        check32("t6_pre_req", mem_req_o, 32'd0);
        rst          = 1'b0;
        mem_rvalid_i = 1'b0;
        #1;
        check32("t6_valid", instr_valid_o, 32'd0);
        check32("t6_instr", instr_o, NOP);
        check32("t6_pc", instr_pc_o, 32'h0000_0000);
        check32("t6_req", mem_req_o, 32'd0);
        check32("t6_addr", mem_addr_o, 32'h0000_0000);
        apply_reset();
        release_reset();
        check32("t6_restart_addr", mem_addr_o, 32'h0000_0000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
